// File: rtl/xor_fold_compactor.sv
// Folds NUM_CH channel streams through a pipelined, valid-aware XOR tree, and keeps a per-run
// signature and word count. Define XOR_FOLD_ROTATE_EN for an order-sensitive (rotate-XOR) signature.
module xor_fold_compactor #(
    parameter int NUM_CH    = 4,
    parameter int DIN_WIDTH = 32,
    parameter int OUT_WIDTH = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        ap_start,
    input  logic                        ap_done,
    input  logic [NUM_CH*DIN_WIDTH-1:0] ch_din,
    input  logic [NUM_CH-1:0]           ch_write,
    output logic [OUT_WIDTH-1:0]        data_out,
    output logic                        data_valid,
    output logic [OUT_WIDTH-1:0]        sig_out,
    output logic [CNT_WIDTH-1:0]        word_cnt,
    output logic                        sig_valid
);

    localparam int LOG2   = $clog2(NUM_CH);
    localparam int LAT    = 2 + LOG2;
    localparam int NODES  = 2 * NUM_CH - 1;
    localparam int SLICES = DIN_WIDTH / OUT_WIDTH;
    localparam int PCW    = $clog2(NUM_CH + 1);
    localparam int DCW    = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Heap-ordered tree: node i has children 2i+1 and 2i+2; leaves hold the stage-1 registers.
    logic [OUT_WIDTH-1:0] node_d [NODES];
    logic [NODES-1:0]     node_v;
    logic [NUM_CH-1:0]    leaf_v;
    logic [PCW-1:0]       leaf_pop;
    logic [CNT_WIDTH:0]   cnt_sum;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [OUT_WIDTH-1:0] sig_next;
    logic [DCW-1:0]       drain_cnt;
    logic                 start_q;
    logic                 start_rise;
    state_t               state;

    function automatic logic [OUT_WIDTH-1:0] fold_word(input logic [DIN_WIDTH-1:0] w);
        logic [OUT_WIDTH-1:0] acc;
        acc = '0;
        for (int s = 0; s < SLICES; s++) acc ^= w[s*OUT_WIDTH +: OUT_WIDTH];
        return acc;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] merge(input logic [OUT_WIDTH-1:0] da, input logic va,
                                                   input logic [OUT_WIDTH-1:0] db, input logic vb);
        case ({va, vb})
            2'b10:   return da;
            2'b01:   return db;
            2'b11:   return da ^ db;
            default: return '0;
        endcase
    endfunction

    function automatic logic [PCW-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_CH; i++) c = c + PCW'(v[i]);
        return c;
    endfunction

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            node_d     <= '{default: '0};
            node_v     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                node_d[NUM_CH-1+k] <= fold_word(ch_din[k*DIN_WIDTH +: DIN_WIDTH]);
                node_v[NUM_CH-1+k] <= ch_write[k];
            end
            for (int i = 0; i < NUM_CH - 1; i++) begin
                node_d[i] <= merge(node_d[2*i+1], node_v[2*i+1], node_d[2*i+2], node_v[2*i+2]);
                node_v[i] <= node_v[2*i+1] | node_v[2*i+2];
            end
            // Leaves carry unmasked folds, so the root is masked here for NUM_CH=1.
            data_out   <= node_v[0] ? node_d[0] : '0;
            data_valid <= node_v[0];
        end
    end

    assign leaf_v     = node_v[NODES-1:NUM_CH-1];
    assign leaf_pop   = popcount(leaf_v);
    assign cnt_sum    = {1'b0, word_cnt} + (CNT_WIDTH+1)'(leaf_pop);
    assign cnt_next   = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    assign start_rise = ap_start & ~start_q;

`ifdef XOR_FOLD_ROTATE_EN
    assign sig_next = ((sig_out << 1) | (sig_out >> (OUT_WIDTH - 1))) ^ data_out;
`else
    assign sig_next = sig_out ^ data_out;
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            sig_out   <= '0;
            word_cnt  <= '0;
            sig_valid <= 1'b0;
            drain_cnt <= '0;
        end else begin
            start_q <= ap_start;
            case (state)
                IDLE, DONE: begin
                    if (start_rise) begin
                        state     <= RUN;
                        sig_out   <= '0;
                        word_cnt  <= '0;
                        sig_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (data_valid) sig_out <= sig_next;
                    word_cnt <= cnt_next;
                    if (ap_done) begin
                        state     <= DRAIN;
                        drain_cnt <= DCW'(LAT);
                    end
                end
                DRAIN: begin
                    if (data_valid) sig_out <= sig_next;
                    word_cnt <= cnt_next;
                    // L cycles after ap_done the last write of the run has been accumulated.
                    if (drain_cnt <= DCW'(1)) begin
                        state     <= DONE;
                        sig_valid <= 1'b1;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - DCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_fold_compactor.sv
// Directed bench for xor_fold_compactor (NUM_CH=4, DIN_WIDTH=32, OUT_WIDTH=4, L=4); a narrow
// 3-bit word counter lets the saturation case be reached in a few writes.
module tb_xor_fold_compactor;

    localparam int NUM_CH    = 4;
    localparam int DIN_WIDTH = 32;
    localparam int OUT_WIDTH = 4;
    localparam int CNT_WIDTH = 3;

`ifdef XOR_FOLD_ROTATE_EN
    localparam logic [3:0] EXP_SIG_T4 = 4'h4;
    localparam logic [3:0] EXP_SIG_T6 = 4'h3;
`else
    localparam logic [3:0] EXP_SIG_T4 = 4'h7;
    localparam logic [3:0] EXP_SIG_T6 = 4'h6;
`endif

    logic                        ap_clk = 1'b0;
    logic                        ap_rst;
    logic                        ap_start;
    logic                        ap_done;
    logic [NUM_CH*DIN_WIDTH-1:0] ch_din;
    logic [NUM_CH-1:0]           ch_write;
    logic [OUT_WIDTH-1:0]        data_out;
    logic                        data_valid;
    logic [OUT_WIDTH-1:0]        sig_out;
    logic [CNT_WIDTH-1:0]        word_cnt;
    logic                        sig_valid;

    int total = 0;
    int bad   = 0;
    logic [OUT_WIDTH-1:0] exp_q[$];

    typedef struct {
        logic [NUM_CH-1:0]           wr;
        logic [NUM_CH*DIN_WIDTH-1:0] din;
        logic [OUT_WIDTH-1:0]        exp_d;
        logic                        exp_v;
    } vec_t;

    vec_t vecs [8];

    xor_fold_compactor #(
        .NUM_CH(NUM_CH), .DIN_WIDTH(DIN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
        .ch_din(ch_din), .ch_write(ch_write), .data_out(data_out), .data_valid(data_valid),
        .sig_out(sig_out), .word_cnt(word_cnt), .sig_valid(sig_valid)
    );

    // ---------------- clock / reset ----------------
    always #5 ap_clk = ~ap_clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drive(input logic [NUM_CH-1:0] wr, input logic [NUM_CH*DIN_WIDTH-1:0] din);
        ch_write = wr;
        ch_din   = din;
    endtask

    task automatic idle_inputs();
        drive('0, '0);
        ap_done = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_data_from_q(input string name);
        logic [OUT_WIDTH-1:0] e;
        e = exp_q.pop_front();
        check({name, "_valid"}, 32'(data_valid), 32'd1);
        check({name, "_data"}, 32'(data_out), 32'(e));
    endtask

    initial begin
        vecs[0] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h12345678}, 4'h8, 1'b1};
        vecs[1] = '{4'b1111, {32'h8, 32'h4, 32'h2, 32'h1}, 4'hF, 1'b1};
        vecs[2] = '{4'b0101, {32'h0, 32'hA, 32'h0, 32'hA}, 4'h0, 1'b1};
        vecs[3] = '{4'b0000, {4{32'hFFFFFFFF}}, 4'h0, 1'b0};
        vecs[4] = '{4'b0010, {32'h0, 32'h0, 32'hC, 32'h3}, 4'hC, 1'b1};
        vecs[5] = '{4'b0110, {32'h0, 32'h50, 32'h3, 32'h0}, 4'h6, 1'b1};
        vecs[6] = '{4'b1001, {32'h9, 32'h0, 32'h0, 32'h11111111}, 4'h9, 1'b1};
        vecs[7] = '{4'b1000, {32'hDEADBEEF, {3{32'hFFFFFFFF}}}, 4'h0, 1'b1};

        ap_rst   = 1'b1;
        ap_start = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_sig_out", 32'(sig_out), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        check("rst_sig_valid", 32'(sig_valid), 32'd0);
        ap_rst = 1'b0;
        tick();

        // Table: one write set, then a quiet pipeline; valid only at exactly t+4.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].wr, vecs[i].din);
            tick();
            idle_inputs();
            for (int c = 0; c < 3; c++) begin
                check($sformatf("vec%0d_early%0d_valid", i, c), 32'(data_valid), 32'd0);
                tick();
            end
            check($sformatf("vec%0d_valid", i), 32'(data_valid), 32'(vecs[i].exp_v));
            check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_d));
            tick();
            check($sformatf("vec%0d_after_valid", i), 32'(data_valid), 32'd0);
            check($sformatf("vec%0d_after_data", i), 32'(data_out), 32'd0);
        end
        check("idle_writes_not_counted", 32'(word_cnt), 32'd0);
        check("idle_sig_valid", 32'(sig_valid), 32'd0);

        // Run with three back-to-back writes on ch0, then ap_done.
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        drive(4'b0001, 128'h1); exp_q.push_back(4'h1); tick();
        drive(4'b0001, 128'h2); exp_q.push_back(4'h2); tick();
        drive(4'b0001, 128'h4); exp_q.push_back(4'h4); tick();
        idle_inputs();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check_data_from_q("run_w1");
        tick();
        check_data_from_q("run_w2");
        tick();
        check_data_from_q("run_w3");
        tick();
        check("run_sig_valid_early", 32'(sig_valid), 32'd0);
        tick();
        check("run_sig_valid", 32'(sig_valid), 32'd1);
        check("run_word_cnt", 32'(word_cnt), 32'd3);
        check("run_sig_out", 32'(sig_out), 32'(EXP_SIG_T4));
        tick();
        tick();
        check("done_hold_sig_valid", 32'(sig_valid), 32'd1);
        check("done_hold_word_cnt", 32'(word_cnt), 32'd3);

        // Reset in the middle of a run discards state and in-flight words.
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        for (int w = 0; w < 5; w++) begin
            drive(4'b0001, 128'h1);
            tick();
        end
        check("pre_rst_word_cnt", 32'(word_cnt), 32'd4);
        idle_inputs();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_data_valid", 32'(data_valid), 32'd0);
        check("midrst_sig_out", 32'(sig_out), 32'd0);
        check("midrst_word_cnt", 32'(word_cnt), 32'd0);
        check("midrst_sig_valid", 32'(sig_valid), 32'd0);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("midrst_flush%0d_valid", c), 32'(data_valid), 32'd0);
            tick();
        end
        check("idle_done_ignored", 32'(sig_valid), 32'd0);

        // Word counter saturates at all-ones (8 writes into a 3-bit counter).
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        drive(4'b1111, '0); tick();
        drive(4'b1111, '0); tick();
        idle_inputs();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("sat_sig_valid", 32'(sig_valid), 32'd1);
        check("sat_word_cnt", 32'(word_cnt), 32'd7);
        check("sat_sig_out", 32'(sig_out), 32'd0);

        // Start edge coinciding with ap_done in RUN: ap_done wins, no clearing.
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        drive(4'b0001, 128'h3);
        tick();
        drive(4'b0001, 128'h5);
        ap_start = 1'b1;
        ap_done  = 1'b1;
        tick();
        ap_start = 1'b0;
        idle_inputs();
        tick();
        tick();
        tick();
        check("collide_sig_valid_early", 32'(sig_valid), 32'd0);
        tick();
        check("collide_sig_valid", 32'(sig_valid), 32'd1);
        check("collide_word_cnt", 32'(word_cnt), 32'd2);
        check("collide_sig_out", 32'(sig_out), 32'(EXP_SIG_T6));
        drive(4'b0001, 128'h7);
        tick();
        idle_inputs();
        for (int c = 0; c < 5; c++) tick();
        check("done_write_not_counted", 32'(word_cnt), 32'd2);
        check("done_write_sig_held", 32'(sig_out), 32'(EXP_SIG_T6));
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        check("restart_sig_valid", 32'(sig_valid), 32'd0);
        check("restart_word_cnt", 32'(word_cnt), 32'd0);
        check("restart_sig_out", 32'(sig_out), 32'd0);

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
